// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory: FSM states and the default boot image.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package instr_mem_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam int IMAGE_LEN = 8;
  localparam int IMAGE_AW  = $clog2(IMAGE_LEN);

  localparam logic [15:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
    16'h9005, 16'h910A, 16'h5201, 16'h3301,
    16'h4401, 16'h1703, 16'h1804, 16'h7F78
  };

  // Image word for a given array index; locations past the image boot as zero.
  function automatic logic [15:0] img_word(input int unsigned idx);
    logic [IMAGE_AW-1:0] w_idx;
    w_idx = idx[IMAGE_AW-1:0];
    if (idx < IMAGE_LEN) begin
      return DEFAULT_IMAGE[w_idx];
    end
    return 16'h0000;
  endfunction

endpackage

// File: rtl/instr_mem_sp_ram_rf.sv
// 1R1W register-file array with a registered, read-first read port.
// Latency: 1 cycle from i_re to o_rd_data; writes land at the accepting edge.
// Backpressure: none; o_rd_data holds whenever i_re is low.
module sp_ram_rf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is deliberately not reset; the boot sequencer rewrites every word.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port: commit the word at the clock edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: samples the pre-edge contents, so a same-address write is read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_re) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem.sv
// Writable instruction memory: boots the default image, then serves valid/ready fetches.
// Latency: 1 cycle from request accept to rsp_valid/rsp_data; writes land at the accepting edge.
// Backpressure: a stalled response blocks new fetches (req_ready low); writes are never stalled in RUN.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_en,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              boot_done
);

  localparam int DEPTH = 1 << ADDR_W;

  // The image must fit in the array; a larger image is a build error, never a silent truncation.
  if (IMAGE_LEN > DEPTH) begin : g_image_fits
    $error("instr_mem: IMAGE_LEN exceeds array depth");
  end

  imem_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rsp_valid;

  logic              w_run;
  logic              w_accept;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_wr_addr;
  logic [DATA_W-1:0] w_ram_wr_data;
  logic [DATA_W-1:0] w_boot_word;
  logic [DATA_W-1:0] w_rd_data;

  assign w_run       = (r_state == RUN);
  assign w_boot_word = DATA_W'(img_word(32'(r_cnt)));

  // Single-entry response slot: a new fetch is taken when the slot is empty or draining now.
  assign req_ready = w_run && (!r_rsp_valid || rsp_ready);
  assign wr_ready  = w_run;
  assign w_accept  = req_valid && req_ready && !rst;

  // Write-port mux: the boot sequencer owns the array until RUN, then the external write port.
  always_comb begin
    w_ram_we      = 1'b0;
    w_ram_wr_addr = wr_addr;
    w_ram_wr_data = wr_data;
    if (!rst) begin
      if (w_run) begin
        w_ram_we = wr_en;
      end else begin
        w_ram_we      = 1'b1;
        w_ram_wr_addr = r_cnt;
        w_ram_wr_data = w_boot_word;
      end
    end
  end

  // Boot sequencer: one image word per cycle, then park in RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_cnt   <= '0;
    end else if (r_state == BOOT) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_state <= RUN;
      end
    end
  end

  // Response valid: set on accept, cleared on a drain with no replacement fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  sp_ram_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_ram_we),
    .i_wr_addr (w_ram_wr_addr),
    .i_wr_data (w_ram_wr_data),
    .i_re      (w_accept),
    .i_rd_addr (req_addr),
    .o_rd_data (w_rd_data)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = w_rd_data;
  assign boot_done = w_run;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem (default 8-word build plus a 16-word build).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: exercised by directed stalls and random rsp_ready.
module tb_instr_mem;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        wr_en;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        boot_done;

  logic        rst4;
  logic        req_valid4;
  logic        req_ready4;
  logic [3:0]  req_addr4;
  logic        rsp_valid4;
  logic        rsp_ready4;
  logic [15:0] rsp_data4;
  logic        wr_en4;
  logic        wr_ready4;
  logic [3:0]  wr_addr4;
  logic [15:0] wr_data4;
  logic        boot_done4;

  int checks   = 0;
  int failures = 0;

  logic [15:0] img [8];
  logic [15:0] ref_mem [8];
  logic        m_valid;
  logic [15:0] m_data;
  logic        exp_rdy;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp;
  } fetch_vec_t;
  fetch_vec_t vecs [8];

  instr_mem #(.DATA_W(16), .ADDR_W(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .boot_done (boot_done)
  );

  instr_mem #(.DATA_W(16), .ADDR_W(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst4),
    .req_valid (req_valid4),
    .req_ready (req_ready4),
    .req_addr  (req_addr4),
    .rsp_valid (rsp_valid4),
    .rsp_ready (rsp_ready4),
    .rsp_data  (rsp_data4),
    .wr_en     (wr_en4),
    .wr_ready  (wr_ready4),
    .wr_addr   (wr_addr4),
    .wr_data   (wr_data4),
    .boot_done (boot_done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    img = '{16'h9005, 16'h910A, 16'h5201, 16'h3301, 16'h4401, 16'h1703, 16'h1804, 16'h7F78};
    vecs[0] = '{3'd0, 16'h9005};
    vecs[1] = '{3'd1, 16'h910A};
    vecs[2] = '{3'd2, 16'h5201};
    vecs[3] = '{3'd3, 16'h3301};
    vecs[4] = '{3'd4, 16'h4401};
    vecs[5] = '{3'd5, 16'h1703};
    vecs[6] = '{3'd6, 16'h1804};
    vecs[7] = '{3'd7, 16'h7F78};

    rst = 1'b1; req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rst4 = 1'b1; req_valid4 = 1'b0; req_addr4 = '0; rsp_ready4 = 1'b1;
    wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data,  0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_ready",  wr_ready,  0);
    chk("rst4_boot_done", boot_done4, 0);
    @(posedge clk); #1;

    // Boot: 8 edges with requests blocked
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      chk("boot_req_ready", req_ready, 0);
      chk("boot_wr_ready",  wr_ready,  0);
      chk("boot_rsp_valid", rsp_valid, 0);
      chk("boot_done_early", boot_done, 0);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("boot_done_rise", boot_done, 1);
    chk("run_wr_ready", wr_ready, 1);

    // Back-to-back fetches from the vector table
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_valid = 1'b1;
        req_addr  = vecs[i].addr;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_req_ready", req_ready, 1);
      if (i > 0) begin
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_rsp_data", rsp_data, vecs[i-1].exp);
      end
      tick();
    end
    @(negedge clk);
    chk("drain_rsp_valid", rsp_valid, 0);
    tick();

    // Backpressure: hold the addr-7 response for 3 cycles
    req_valid = 1'b1; req_addr = 3'd7; rsp_ready = 1'b1;
    tick();
    req_addr = 3'd0; rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data",  rsp_data,  16'h7F78);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", rsp_valid, 1);
    chk("bp_next_data",  rsp_data,  16'h9005);
    tick();

    // Same-cycle read/write to addr 2 is read-first
    req_valid = 1'b1; req_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hABCD;
    @(negedge clk);
    chk("rw_wr_ready", wr_ready, 1);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("rw_old_word", rsp_data, 16'h5201);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("rw_new_word", rsp_data, 16'hABCD);
    tick();

    // Reset clears a stalled response; reset mid-boot restarts the full copy
    req_valid = 1'b1; req_addr = 3'd1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_rsp_valid", rsp_valid, 0);
    chk("rst_back_to_boot", boot_done, 0);
    rsp_ready = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      chk("reboot_done_early", boot_done, 0);
      tick();
    end
    @(negedge clk);
    chk("reboot_done_rise", boot_done, 1);
    req_valid = 1'b1; req_addr = 3'd2;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("reboot_patch_gone", rsp_data, 16'h5201);
    tick();

    // Randomized traffic against a memory-array reference model
    for (int k = 0; k < 8; k++) ref_mem[k] = img[k];
    m_valid = 1'b0;
    m_data  = 16'h5201;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      @(negedge clk);
      exp_rdy = !m_valid || rsp_ready;
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, m_valid);
      if (m_valid) chk("rnd_rsp_data", rsp_data, m_data);
      @(posedge clk);
      if (req_valid && exp_rdy) begin
        m_valid = 1'b1;
        m_data  = ref_mem[req_addr];
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      if (wr_en) ref_mem[wr_addr] = wr_data;
      #1;
    end
    req_valid = 1'b0; wr_en = 1'b0;

    // 16-word build: longer boot, zero-filled tail
    rst4 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      chk("b16_done_early", boot_done4, 0);
      tick();
    end
    @(negedge clk);
    chk("b16_done_rise", boot_done4, 1);
    chk("b16_wr_ready", wr_ready4, 1);
    tick();
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        req_valid4 = 1'b1;
        req_addr4  = 4'(i);
      end else begin
        req_valid4 = 1'b0;
      end
      @(negedge clk);
      chk("b16_req_ready", req_ready4, 1);
      if (i > 0) begin
        chk("b16_rsp_valid", rsp_valid4, 1);
        chk("b16_rsp_data", rsp_data4, (i - 1 < 8) ? img[(i - 1) % 8] : 16'h0000);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
